// File: rtl/alu_multiciclo.sv
// alu_multiciclo: registered multicycle ALU with a valid/ready handshake on
// both sides. Logic, add/sub, compare and shift operations produce their
// result one cycle after acceptance. MUL uses an iterative shift-add engine
// that takes WIDTH cycles. Each result is held until downstream takes it.
//
// Optional feature macro: ALU_MUL_EN
//   defined   -> opcode 1011 (MUL) and the MUL_BUSY state/datapath are built
//   undefined -> no multiply hardware; 1011 is handled as an illegal opcode
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands/opcode valid
//   in_ready   block can accept an operation (high only in IDLE)
//   OP1, OP2   operands; shift amount is OP2[SHW-1:0]
//   ALUSel     4-bit opcode
//   out_valid  Res/Z/Ovf/Err valid (high only in DONE)
//   out_ready  downstream accepts the result
//   Res        result
//   Z          Res == 0 (legal ops only)
//   Ovf        signed overflow for ADD/SUB, else 0
//   Err        illegal opcode flag
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The source holds its data while valid is high and ready is low;
// the ALU holds Res/Z/Ovf/Err stable while out_valid is high and out_ready
// is low. Acceptance and retirement never happen in the same cycle.
module alu_multiciclo #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  input  logic [3:0]       ALUSel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Res,
  output logic             Z,
  output logic             Ovf,
  output logic             Err
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MUL_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1011;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_next;
`endif

  // Single-cycle datapath
  logic [WIDTH-1:0] sum, diff;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_err;

  assign sum  = OP1 + OP2;
  assign diff = OP1 - OP2;
  assign sh   = OP2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (ALUSel)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (sum[WIDTH-1] != OP1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (diff[WIDTH-1] != OP1[WIDTH-1]);
      end
      OP_AND:  alu_res = OP1 & OP2;
      OP_OR:   alu_res = OP1 | OP2;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (OP1 < OP2)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
      OP_NOR:  alu_res = ~(OP1 | OP2);
      OP_XOR:  alu_res = OP1 ^ OP2;
      OP_SLL:  alu_res = OP1 << sh;
      OP_SRL:  alu_res = OP1 >> sh;
      OP_SRA:  alu_res = $unsigned($signed(OP1) >>> sh);
`ifdef ALU_MUL_EN
      // The real product is produced by the iterative engine; nothing from
      // this branch is ever made visible.
      OP_MUL:  alu_res = '0;
`endif
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    z_d     = z_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_DONE;
          res_d   = alu_res;
          // Illegal opcodes report Z=0 even though Res is zero.
          z_d     = !alu_err && (alu_res == '0);
          ovf_d   = alu_ovf;
          err_d   = alu_err;
`ifdef ALU_MUL_EN
          if (ALUSel == OP_MUL) begin
            state_d  = ST_MUL_BUSY;
            mcand_d  = OP1;
            mplier_d = OP2;
            acc_d    = '0;
            cnt_d    = '0;
          end
`endif
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL_BUSY: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        // The last iteration writes the result directly from acc_next.
        if (cnt_q == SHW'(WIDTH-1)) begin
          state_d = ST_DONE;
          res_d   = acc_next;
          z_d     = (acc_next == '0);
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      z_q     <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign Res       = res_q;
  assign Z         = z_q;
  assign Ovf       = ovf_q;
  assign Err       = err_q;

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
- Parametrised, registered successor to the combinational datapath ALU.
- Accepts one operation per valid/ready handshake.
- Logic, add/sub, compare and shift ops: one cycle. Multiply: iterative shift-add engine, WIDTH cycles.
- Sits between the register-file read stage and the writeback/branch logic of the multicycle datapath. Holds each result until downstream accepts it.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, ≥ 8.
- SHW, $clog2(WIDTH), shift-amount field width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept an operation
- OP1  input  WIDTH  operand A
- OP2  input  WIDTH  operand B; shift amount = OP2[SHW-1:0]
- ALUSel  input  4  opcode
- out_valid  output  1  Res/Z/Ovf/Err valid
- out_ready  input  1  downstream accepts result
- Res  output  WIDTH  result
- Z  output  1  Res == 0
- Ovf  output  1  signed overflow (ADD/SUB only, else 0)
- Err  output  1  illegal opcode flag

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR.
  - 0100 SLTU (unsigned OP1<OP2 → 1 else 0).
  - 0101 SLT (signed), 0110 NOR, 0111 XOR.
  - 1000 SLL, 1001 SRL, 1010 SRA.
  - 1011 MUL (low WIDTH bits of unsigned product).
  - 1100–1111 illegal.
- Reset (rst high at clk edge, any state): state=IDLE; Res=0, Z=0, Ovf=0, Err=0, out_valid=0; in_ready=1 on the following cycle. Reset aborts any multiply in progress; the partial result is discarded.
- FSM states: IDLE, MUL_BUSY, DONE.
  - IDLE: in_ready=1, out_valid=0. Accept when in_valid&&in_ready.
    - Non-MUL: result registered at the accept edge → DONE. Latency 1 cycle.
    - MUL: load multiplicand, multiplier, accumulator=0, counter=0 → MUL_BUSY.
  - MUL_BUSY: in_ready=0, out_valid=0. Each cycle: if multiplier LSB=1, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++. After WIDTH iterations (counter==WIDTH-1 step done), Res=acc → DONE. Latency WIDTH+1 cycles from accept to out_valid.
  - DONE: out_valid=1, in_ready=0. Outputs stable while out_valid&&!out_ready. On out_ready → IDLE (out_valid drops next cycle). No back-to-back accept in the same cycle as result retire; throughput ≤ 1 op / 2 cycles.
- Flags, registered with Res:
  - Z = (Res==0) for every legal op, including SLT/SLTU.
  - Ovf (ADD) = OP1[MSB]==OP2[MSB] && Res[MSB]!=OP1[MSB].
  - Ovf (SUB) = OP1[MSB]!=OP2[MSB] && Res[MSB]!=OP1[MSB].
- Illegal opcode: accepted normally, latency 1. Res=0, Z=0, Ovf=0, Err=1. No X/Z values are ever driven on outputs.
- Shifts use only OP2[SHW-1:0]; upper OP2 bits are ignored. SRA replicates OP1[MSB].
- ADD/SUB/MUL wrap modulo 2^WIDTH.
- in_valid while in_ready=0 is ignored; the source must hold its data.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: MUL opcode 1011 and the MUL_BUSY state/datapath are built as described.
- Undefined: no multiply hardware and no MUL_BUSY state. 1011 is treated as illegal (Res=0, Err=1, latency 1).

Test Plan:
- ADD: OP1=32'h7FFFFFFF, OP2=1, ALUSel=0000 → one cycle later out_valid=1, Res=32'h80000000, Ovf=1, Z=0, Err=0.
- SUB equal: OP1=OP2=32'h1234 → Res=0, Z=1, Ovf=0. Then SLT with OP1=32'hFFFFFFFF, OP2=1 → Res=1; SLTU with the same operands → Res=0, Z=1.
- Shifts: OP1=32'h80000000, OP2=32'h00000024 (amount 4) → SRA=32'hF8000000, SRL=32'h08000000, SLL=0 with Z=1.
- MUL (ALU_MUL_EN defined): OP1=32'h0001_0001, OP2=32'h0000_FFFF → in_ready low for 32 cycles; out_valid at cycle 33 after accept; Res=32'hFFFF_FFFF. Without the macro → Err=1, Res=0 after 1 cycle.
- Backpressure/reset: hold out_ready=0 for 5 cycles after an OR of 32'hF0/32'h0F → Res=32'hFF, stable, in_ready=0. Assert rst mid-MUL (cycle 10) → next cycle out_valid=0, Res=0, in_ready=1; no stale result ever appears.
- Illegal opcode 1110 with random operands → Res=0, Z=0, Err=1, out_valid after 1 cycle. The next legal op clears Err.
